// File: rtl/bcp_implication_applier_pkg.sv
// Shared definitions for the BCP implication applier slice.
// Holds the controller state encoding, the default variable count and a
// constant clog2 helper used to size index and length fields.
package bcp_implication_applier_pkg;

  localparam int VAR_NUM_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONFLICT  = 2'd1,
    ST_BACKTRACK = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcp_trail_stack.sv
// LIFO holding the order in which variables were assigned.
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset (length only)
//   i_push, i_push_idx : push a variable index onto the stack
//   i_pop            : discard the top entry
//   o_top            : index currently on top (valid when o_len != 0)
//   o_len            : number of entries held
// The entry storage is never reset; only the length register is, so stale
// entries above the length are simply ignored.
module bcp_trail_stack
  import bcp_implication_applier_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int LEN_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [IDX_W-1:0] i_push_idx,
  input  logic             i_pop,
  output logic [IDX_W-1:0] o_top,
  output logic [LEN_W-1:0] o_len
);

  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] w_wr_ptr;
  logic [IDX_W-1:0] w_top_ptr;

  // The length never exceeds DEPTH-1 when pushing, so truncation is safe.
  assign w_wr_ptr  = IDX_W'(r_len);
  assign w_top_ptr = IDX_W'(r_len - LEN_W'(1));
  assign o_top     = r_mem[w_top_ptr];
  assign o_len     = r_len;

  // Entry storage, written on push only.
  always_ff @(posedge i_clock) begin
    if (i_push) begin
      r_mem[w_wr_ptr] <= i_push_idx;
    end
  end

  // Stack depth counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_len <= '0;
    end else if (i_push) begin
      r_len <= r_len + LEN_W'(1);
    end else if (i_pop) begin
      r_len <= r_len - LEN_W'(1);
    end
  end

endmodule

// File: rtl/bcp_implication_applier.sv
// Consumer end of the BCP clause-check interface.
// Applies unit implications and decisions to the free/assignment vectors,
// records each new assignment on a trail, flags contradictions as a sticky
// conflict and unwinds the trail one entry per cycle on a backtrack request.
// Ports:
//   i_clock, i_reset              : clock, synchronous active-high reset
//   i_imp_valid/o_imp_ready       : implication handshake
//   i_imp_mask, i_imp_value       : one-hot variable select and polarity
//   i_dec_valid/o_dec_ready       : decision handshake
//   i_dec_index, i_dec_value      : decided variable and polarity
//   i_bt_valid, i_bt_level        : backtrack request and target trail length
//   o_bt_done                     : one-cycle pulse when backtrack completes
//   o_conflict                    : sticky contradiction flag
//   o_err                         : one-cycle pulse on a malformed request
//   o_free, o_assignment          : per-variable state vectors
//   o_trail_len                   : current trail depth
module bcp_implication_applier
  import bcp_implication_applier_pkg::*;
#(
  parameter int VAR_NUM = VAR_NUM_DEF,
  parameter int IDX_W   = clog2(VAR_NUM),
  parameter int LEN_W   = clog2(VAR_NUM + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_imp_valid,
  output logic               o_imp_ready,
  input  logic [VAR_NUM-1:0] i_imp_mask,
  input  logic [VAR_NUM-1:0] i_imp_value,
  input  logic               i_dec_valid,
  output logic               o_dec_ready,
  input  logic [IDX_W-1:0]   i_dec_index,
  input  logic               i_dec_value,
  input  logic               i_bt_valid,
  input  logic [LEN_W-1:0]   i_bt_level,
  output logic               o_bt_done,
  output logic               o_conflict,
  output logic               o_err,
  output logic [VAR_NUM-1:0] o_free,
  output logic [VAR_NUM-1:0] o_assignment,
  output logic [LEN_W-1:0]   o_trail_len
);

  state_e             r_state;
  logic               r_conflict;
  logic               r_bt_done;
  logic               r_err;
  logic [LEN_W-1:0]   r_target;
  logic [VAR_NUM-1:0] r_free;
  logic [VAR_NUM-1:0] r_assign;

  logic               w_imp_ready;
  logic               w_dec_ready;
  logic               w_imp_fire;
  logic               w_dec_fire;
  logic               w_req_fire;
  logic [IDX_W-1:0]   w_imp_idx;
  logic [LEN_W-1:0]   w_imp_cnt;
  logic [IDX_W:0]     w_dec_ext;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_req_val;
  logic               w_req_bad;
  logic               w_push;
  logic               w_pop;
  logic               w_pop_last;
  logic               w_bt_start;
  logic               w_bt_short;
  logic [LEN_W-1:0]   w_tgt;
  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_top;

  bcp_trail_stack #(
    .DEPTH (VAR_NUM),
    .IDX_W (IDX_W),
    .LEN_W (LEN_W)
  ) u_trail (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_idx (w_req_idx),
    .i_pop      (w_pop),
    .o_top      (w_top),
    .o_len      (w_len)
  );

  // One-hot to index encoder and popcount of the implication mask.
  always_comb begin
    w_imp_idx = '0;
    w_imp_cnt = '0;
    for (int i = 0; i < VAR_NUM; i++) begin
      w_imp_cnt = w_imp_cnt + LEN_W'(i_imp_mask[i]);
      if (i_imp_mask[i]) begin
        w_imp_idx = w_imp_idx | IDX_W'(i);
      end else begin
        w_imp_idx = w_imp_idx;
      end
    end
  end

  // Handshake, request decode and trail push/pop control.
  always_comb begin
    // A backtrack request in the same cycle blocks both request channels.
    w_imp_ready = (r_state == ST_IDLE) & ~i_bt_valid;
    w_dec_ready = w_imp_ready & ~i_imp_valid;
    w_imp_fire  = i_imp_valid & w_imp_ready;
    w_dec_fire  = i_dec_valid & w_dec_ready;
    w_req_fire  = w_imp_fire | w_dec_fire;
    w_dec_ext   = {1'b0, i_dec_index};
    if (w_imp_fire) begin
      w_req_idx = w_imp_idx;
      w_req_val = |(i_imp_value & i_imp_mask);
      w_req_bad = (w_imp_cnt != LEN_W'(1));
    end else begin
      w_req_idx = i_dec_index;
      w_req_val = i_dec_value;
      w_req_bad = (w_dec_ext >= (IDX_W + 1)'(VAR_NUM));
    end
    w_push = w_req_fire & ~w_req_bad & r_free[w_req_idx];

    // The first pop happens on the cycle the request is sampled, so the
    // latency to bt_done equals the number of entries removed.
    w_bt_start = i_bt_valid & ((r_state == ST_IDLE) | (r_state == ST_CONFLICT));
    w_bt_short = w_bt_start & (i_bt_level >= w_len);
    w_tgt      = w_bt_start ? i_bt_level : r_target;
    w_pop      = (w_bt_start & ~w_bt_short) | (r_state == ST_BACKTRACK);
    w_pop_last = w_pop & ((w_len - LEN_W'(1)) == w_tgt);
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_conflict <= 1'b0;
      r_bt_done  <= 1'b0;
      r_err      <= 1'b0;
      r_target   <= '0;
    end else begin
      r_bt_done <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_CONFLICT: begin
          if (w_bt_start) begin
            r_target <= i_bt_level;
            if (w_bt_short || w_pop_last) begin
              r_bt_done  <= 1'b1;
              r_conflict <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_state <= ST_BACKTRACK;
            end
          end else if (w_req_fire) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else if (!r_free[w_req_idx] && (r_assign[w_req_idx] != w_req_val)) begin
              r_conflict <= 1'b1;
              r_state    <= ST_CONFLICT;
            end
          end
        end
        ST_BACKTRACK: begin
          if (w_pop_last) begin
            r_bt_done  <= 1'b1;
            r_conflict <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Free and assignment vectors, updated by trail push or pop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_free   <= '1;
      r_assign <= '0;
    end else if (w_push) begin
      r_free[w_req_idx]   <= 1'b0;
      r_assign[w_req_idx] <= w_req_val;
    end else if (w_pop) begin
      r_free[w_top]   <= 1'b1;
      r_assign[w_top] <= 1'b0;
    end
  end

  assign o_imp_ready  = w_imp_ready;
  assign o_dec_ready  = w_dec_ready;
  assign o_bt_done    = r_bt_done;
  assign o_conflict   = r_conflict;
  assign o_err        = r_err;
  assign o_free       = r_free;
  assign o_assignment = r_assign;
  assign o_trail_len  = w_len;

endmodule
